// File: rtl/seq_pkg.sv
// seq_pkg: shared encodings and helpers for the
// sequence-check frame path (serializer + checker).
package seq_pkg;

  localparam logic [1:0] SER_IDLE  = 2'd0;
  localparam logic [1:0] SER_SHIFT = 2'd1;
  localparam logic [1:0] SER_GAP   = 2'd2;

  localparam logic [2:0] CHK_S0 = 3'd0;
  localparam logic [2:0] CHK_S1 = 3'd1;
  localparam logic [2:0] CHK_S2 = 3'd2;
  localparam logic [2:0] CHK_S3 = 3'd3;
  localparam logic [2:0] CHK_S4 = 3'd4;
  localparam logic [2:0] CHK_S5 = 3'd5;
  localparam logic [2:0] CHK_S6 = 3'd6;
  localparam logic [2:0] CHK_S7 = 3'd7;

  function automatic int len_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

  function automatic int eff_len(
    input int len,
    input int data_w
  );
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// seq_down_counter: loadable down counter that
// parks at zero and flags it.
module seq_down_counter #(
  parameter int W = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // load has priority; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/seq_frame_serializer.sv
// seq_frame_serializer: shifts a parallel frame into
// the serial sequence checker, one bit per clk.
module seq_frame_serializer
  import seq_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter bit LSB_FIRST  = 1'b0,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [DATA_W-1:0]           s_data,
  input  logic [$clog2(DATA_W+1)-1:0] s_len,
  input  logic                        abort,
  output logic                        ser_bit,
  output logic                        ser_valid,
  output logic                        chk_hold,
  output logic                        result_valid,
  output logic [CNT_W-1:0]            frame_cnt,
  output logic                        busy
);

  localparam int LEN_W = len_w(DATA_W);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] load_word;
  logic [LEN_W-1:0]  len_eff;
  logic              accept;
  logic              bit_zero;
  logic              gap_zero;
  logic              frame_done;

  assign len_eff = LEN_W'(eff_len(int'(s_len), DATA_W));

  assign s_ready    = (state == SER_IDLE) && !abort;
  assign accept     = s_valid && s_ready;
  assign ser_valid  = (state == SER_SHIFT);
  assign chk_hold   = !ser_valid;
  assign busy       = (state != SER_IDLE);
  assign frame_done = ser_valid && bit_zero && !abort;

  // short MSB-first frames are left-aligned so the
  // top bit of the register is always the next bit
  assign load_word = LSB_FIRST ? s_data :
    (s_data << (LEN_W'(DATA_W) - len_eff));

  assign ser_bit = ser_valid &&
    (LSB_FIRST ? shreg[0] : shreg[DATA_W-1]);

  seq_down_counter #(
    .W(LEN_W)
  ) u_bit_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (len_eff - LEN_W'(1)),
    .dec      (ser_valid),
    .zero     (bit_zero)
  );

  if (GAP_CYCLES > 0) begin : g_gap
    localparam int GAP_W =
      (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    seq_down_counter #(
      .W(GAP_W)
    ) u_gap_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (frame_done),
      .load_val (GAP_W'(GAP_CYCLES - 1)),
      .dec      (state == SER_GAP),
      .zero     (gap_zero)
    );
  end else begin : g_no_gap
    assign gap_zero = 1'b1;
  end

  // next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      SER_IDLE: begin
        if (accept) state_nxt = SER_SHIFT;
      end
      SER_SHIFT: begin
        if (abort)
          state_nxt = SER_IDLE;
        else if (bit_zero)
          state_nxt = (GAP_CYCLES > 0) ?
            SER_GAP : SER_IDLE;
      end
      SER_GAP: begin
        if (abort || gap_zero) state_nxt = SER_IDLE;
      end
      default: state_nxt = SER_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SER_IDLE;
    else        state <= state_nxt;
  end

  // frame shift register, loaded on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shreg <= '0;
    else if (accept)
      shreg <= load_word;
    else if (ser_valid)
      shreg <= LSB_FIRST ? (shreg >> 1) : (shreg << 1);
  end

  // result strobe and completed-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_valid <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      result_valid <= frame_done;
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_frame_serializer.sv
// tb_seq_frame_serializer: vector table, corner
// sequences and random traffic on two configurations.
module tb_seq_frame_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_n;
  logic [1:0] s_valid;
  logic [1:0] abort;
  logic [7:0] s_data [2];
  logic [3:0] s_len  [2];

  wire [1:0]  s_ready;
  wire [1:0]  ser_bit;
  wire [1:0]  ser_valid;
  wire [1:0]  chk_hold;
  wire [1:0]  rv;
  wire [1:0]  busy;
  wire [1:0]  chk_out;
  wire [15:0] cnt_a;
  wire [2:0]  cnt_b;

  int checks   = 0;
  int failures = 0;
  int exp_cnt [2];

  // dut 0: MSB first, no gap, 16-bit counter
  seq_frame_serializer #(
    .DATA_W(8), .LSB_FIRST(1'b0),
    .GAP_CYCLES(0), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n[0]),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .s_data(s_data[0]), .s_len(s_len[0]),
    .abort(abort[0]), .ser_bit(ser_bit[0]),
    .ser_valid(ser_valid[0]), .chk_hold(chk_hold[0]),
    .result_valid(rv[0]), .frame_cnt(cnt_a),
    .busy(busy[0])
  );

  // dut 1: LSB first, 3 gap cycles, 3-bit counter
  seq_frame_serializer #(
    .DATA_W(8), .LSB_FIRST(1'b1),
    .GAP_CYCLES(3), .CNT_W(3)
  ) dut_b (
    .clk(clk), .rst_n(rst_n[1]),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .s_data(s_data[1]), .s_len(s_len[1]),
    .abort(abort[1]), .ser_bit(ser_bit[1]),
    .ser_valid(ser_valid[1]), .chk_hold(chk_hold[1]),
    .result_valid(rv[1]), .frame_cnt(cnt_b),
    .busy(busy[1])
  );

  // behavioural checker: >=3 zeros and >=1 one
  for (genvar g = 0; g < 2; g++) begin : g_chk
    logic [1:0] zeros;
    logic       one;
    always @(posedge clk or negedge rst_n[g]) begin
      if (!rst_n[g]) begin
        zeros <= '0;
        one   <= 1'b0;
      end else if (chk_hold[g]) begin
        zeros <= '0;
        one   <= 1'b0;
      end else if (ser_bit[g]) begin
        one <= 1'b1;
      end else if (zeros != 2'd3) begin
        zeros <= zeros + 2'd1;
      end
    end
    assign chk_out[g] = (zeros == 2'd3) && one;
  end

  function automatic int gap_of(input int d);
    return (d == 1) ? 3 : 0;
  endfunction

  function automatic int cnt_mask(input int d);
    return (d == 1) ? 7 : 65535;
  endfunction

  function automatic int cnt_of(input int d);
    return (d == 1) ? int'(cnt_b) : int'(cnt_a);
  endfunction

  task automatic check1(
    input string name, input int d,
    input logic act, input logic exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%b want=%b",
               name, d, $time, act, exp);
    end
  endtask

  task automatic check_cnt(
    input string name, input int d,
    input int act, input int exp
  );
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%0d want=%0d",
               name, d, $time, act, exp);
    end
  endtask

  task automatic check_reset(input int d);
    check1("rst_ser_bit", d, ser_bit[d], 1'b0);
    check1("rst_ser_valid", d, ser_valid[d], 1'b0);
    check1("rst_chk_hold", d, chk_hold[d], 1'b1);
    check1("rst_rv", d, rv[d], 1'b0);
    check1("rst_busy", d, busy[d], 1'b0);
    check_cnt("rst_cnt", d, cnt_of(d), 0);
  endtask

  // one frame; seq lists bits in send order, first
  // bit at seq[n-1]
  task automatic run_frame(
    input int d, input logic [7:0] data,
    input logic [3:0] len, input int n,
    input logic [7:0] seq, input logic out
  );
    @(negedge clk);
    s_valid[d] = 1'b1;
    s_data[d]  = data;
    s_len[d]   = len;
    #1 check1("acc_ready", d, s_ready[d], 1'b1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s_valid[d] = 1'b0;
      s_data[d]  = 8'($urandom);
      s_len[d]   = 4'($urandom);
      #1;
      check1("bit_valid", d, ser_valid[d], 1'b1);
      check1("bit_hold", d, chk_hold[d], 1'b0);
      check1("bit_val", d, ser_bit[d], seq[n-1-i]);
      check1("bit_no_rv", d, rv[d], 1'b0);
    end
    exp_cnt[d] = (exp_cnt[d] + 1) & cnt_mask(d);
    @(negedge clk);
    #1;
    check1("rv", d, rv[d], 1'b1);
    check1("rv_hold", d, chk_hold[d], 1'b1);
    check1("rv_out", d, chk_out[d], out);
    check1("rv_ready", d, s_ready[d], gap_of(d) == 0);
    check_cnt("rv_cnt", d, cnt_of(d), exp_cnt[d]);
    for (int i = 1; i < gap_of(d); i++) begin
      @(negedge clk);
      #1;
      check1("gap_ready", d, s_ready[d], 1'b0);
      check1("gap_rv", d, rv[d], 1'b0);
      check1("gap_valid", d, ser_valid[d], 1'b0);
    end
  endtask

  typedef struct packed {
    logic       d;
    logic [7:0] data;
    logic [3:0] len;
    logic [3:0] n;
    logic [7:0] seq;
    logic       out;
  } vec_t;

  vec_t vecs [11];

  int         m_left [2];
  int         m_pos  [2];
  int         m_len  [2];
  int         m_gap  [2];
  logic [7:0] m_data [2];
  logic       m_rv   [2];
  logic       m_out  [2];

  initial begin
    vecs[0]  = '{1'b0, 8'h10, 4'd8,  4'd8, 8'b0001_0000, 1'b1};
    vecs[1]  = '{1'b0, 8'h03, 4'd3,  4'd3, 8'b011,       1'b0};
    vecs[2]  = '{1'b0, 8'hFF, 4'd0,  4'd8, 8'b1111_1111, 1'b0};
    vecs[3]  = '{1'b0, 8'h01, 4'd4,  4'd4, 8'b0001,      1'b1};
    vecs[4]  = '{1'b0, 8'hA5, 4'd12, 4'd8, 8'b1010_0101, 1'b1};
    vecs[5]  = '{1'b0, 8'h00, 4'd1,  4'd1, 8'b0,         1'b0};
    vecs[6]  = '{1'b0, 8'hE8, 4'd5,  4'd5, 8'b01000,     1'b1};
    vecs[7]  = '{1'b1, 8'h08, 4'd8,  4'd8, 8'b0001_0000, 1'b1};
    vecs[8]  = '{1'b1, 8'h03, 4'd3,  4'd3, 8'b110,       1'b0};
    vecs[9]  = '{1'b1, 8'hF0, 4'd0,  4'd8, 8'b0000_1111, 1'b1};
    vecs[10] = '{1'b1, 8'h16, 4'd5,  4'd5, 8'b01101,     1'b0};

    rst_n     = 2'b00;
    s_valid   = 2'b00;
    abort     = 2'b00;
    s_data[0] = 8'h00;
    s_data[1] = 8'h00;
    s_len[0]  = 4'd0;
    s_len[1]  = 4'd0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;

    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_reset(d);
    @(negedge clk);
    rst_n = 2'b11;

    for (int v = 0; v < 11; v++)
      run_frame(int'(vecs[v].d), vecs[v].data,
                vecs[v].len, int'(vecs[v].n),
                vecs[v].seq, vecs[v].out);

    // back-to-back, s_valid held, no gap
    s_data[0] = 8'h01;
    s_len[0]  = 4'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_valid[0] = (i < 9);
      #1;
      check1("b2b_ready", 0, s_ready[0], i % 3 == 0);
      check1("b2b_hold", 0, chk_hold[0], i % 3 == 0);
      check1("b2b_rv", 0, rv[0], i % 3 == 0 && i > 0);
      if (i % 3 != 0)
        check1("b2b_bit", 0, ser_bit[0], i % 3 == 2);
    end
    exp_cnt[0] += 3;
    check_cnt("b2b_cnt", 0, cnt_of(0), exp_cnt[0]);

    // 3-cycle gap, s_valid held
    s_data[1] = 8'h01;
    s_len[1]  = 4'd1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s_valid[1] = (i < 10);
      #1;
      check1("gp_ready", 1, s_ready[1], i % 5 == 0);
      check1("gp_ser", 1, ser_valid[1], i % 5 == 1);
      check1("gp_rv", 1, rv[1], i % 5 == 2);
    end
    exp_cnt[1] = (exp_cnt[1] + 2) & 7;
    check_cnt("gp_cnt", 1, cnt_of(1), exp_cnt[1]);

    // abort at bit 4 of 8
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h10;
    s_len[0]   = 4'd8;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      s_valid[0] = 1'b0;
      abort[0]   = (i == 4);
      #1;
      if (i <= 4) begin
        check1("ab_sv", 0, ser_valid[0], 1'b1);
      end else begin
        check1("ab_drop", 0, ser_valid[0], 1'b0);
        check1("ab_hold", 0, chk_hold[0], 1'b1);
        check1("ab_rv", 0, rv[0], 1'b0);
        check1("ab_bit", 0, ser_bit[0], 1'b0);
      end
      if (i >= 6) check1("ab_s0", 0, chk_out[0], 1'b0);
    end
    check_cnt("ab_cnt", 0, cnt_of(0), exp_cnt[0]);

    // abort on the last bit
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'h01;
    s_len[0]   = 4'd2;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      s_valid[0] = 1'b0;
      abort[0]   = (i == 2);
      #1;
      if (i >= 3) begin
        check1("abl_rv", 0, rv[0], 1'b0);
        check1("abl_sv", 0, ser_valid[0], 1'b0);
      end
    end
    check_cnt("abl_cnt", 0, cnt_of(0), exp_cnt[0]);

    // abort while idle blocks acceptance
    @(negedge clk);
    s_valid[0] = 1'b1;
    abort[0]   = 1'b1;
    #1 check1("abi_ready", 0, s_ready[0], 1'b0);
    @(negedge clk);
    s_valid[0] = 1'b0;
    abort[0]   = 1'b0;
    #1 check1("abi_busy", 0, busy[0], 1'b0);

    // abort in the gap
    @(negedge clk);
    s_valid[1] = 1'b1;
    s_data[1]  = 8'h01;
    s_len[1]   = 4'd1;
    @(negedge clk);
    s_valid[1] = 1'b0;
    @(negedge clk);
    abort[1] = 1'b1;
    #1;
    check1("abg_rv", 1, rv[1], 1'b1);
    check1("abg_ready", 1, s_ready[1], 1'b0);
    exp_cnt[1] = (exp_cnt[1] + 1) & 7;
    @(negedge clk);
    abort[1] = 1'b0;
    #1;
    check1("abg_idle", 1, s_ready[1], 1'b1);
    check1("abg_busy", 1, busy[1], 1'b0);

    // reset mid-frame
    @(negedge clk);
    s_valid[0] = 1'b1;
    s_data[0]  = 8'hFF;
    s_len[0]   = 4'd8;
    @(negedge clk);
    s_valid[0] = 1'b0;
    @(negedge clk);
    #1 check1("mr_busy", 0, busy[0], 1'b1);
    rst_n[0] = 1'b0;
    #1 check_reset(0);
    exp_cnt[0] = 0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1 check1("mr_no_rv", 0, rv[0], 1'b0);
    end
    run_frame(0, 8'h10, 4'd8, 8, 8'b0001_0000, 1'b1);

    // counter wrap on the 3-bit instance
    while (exp_cnt[1] != 7)
      run_frame(1, 8'h01, 4'd1, 1, 8'b1, 1'b0);
    run_frame(1, 8'h08, 4'd8, 8, 8'b0001_0000, 1'b1);
    check_cnt("wrap", 1, cnt_of(1), 0);

    // random traffic against a frame-level model
    for (int d = 0; d < 2; d++) begin
      m_left[d] = 0;
      m_gap[d]  = 0;
      m_rv[d]   = 1'b0;
      m_out[d]  = 1'b0;
      m_pos[d]  = 0;
      m_len[d]  = 8;
      m_data[d] = 8'h00;
    end
    repeat (600) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        s_valid[d] = 1'($urandom_range(0, 1));
        abort[d]   = ($urandom_range(0, 15) == 0);
        s_data[d]  = 8'($urandom);
        s_len[d]   = 4'($urandom);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        logic exp_ready;
        logic exp_bit;
        int   idx;
        exp_ready = (m_left[d] == 0) &&
                    (m_gap[d] == 0) && !abort[d];
        exp_bit = 1'b0;
        if (m_left[d] > 0) begin
          idx = (d == 1) ? m_pos[d] :
                           m_len[d] - 1 - m_pos[d];
          exp_bit = m_data[d][idx];
        end
        check1("r_ready", d, s_ready[d], exp_ready);
        check1("r_valid", d, ser_valid[d], m_left[d] > 0);
        check1("r_bit", d, ser_bit[d], exp_bit);
        check1("r_rv", d, rv[d], m_rv[d]);
        check1("r_busy", d, busy[d],
               m_left[d] > 0 || m_gap[d] > 0);
        check_cnt("r_cnt", d, cnt_of(d), exp_cnt[d]);
        if (m_rv[d])
          check1("r_out", d, chk_out[d], m_out[d]);

        m_rv[d] = 1'b0;
        if (m_left[d] > 0) begin
          if (abort[d]) begin
            m_left[d] = 0;
          end else begin
            m_pos[d]++;
            m_left[d]--;
            if (m_left[d] == 0) begin
              int ones;
              ones = $countones(
                m_data[d] & 8'((1 << m_len[d]) - 1));
              m_rv[d]  = 1'b1;
              m_out[d] = (m_len[d] - ones >= 3) &&
                         (ones >= 1);
              m_gap[d] = gap_of(d);
              exp_cnt[d] = (exp_cnt[d] + 1) & cnt_mask(d);
            end
          end
        end else if (m_gap[d] > 0) begin
          m_gap[d] = abort[d] ? 0 : m_gap[d] - 1;
        end else if (exp_ready && s_valid[d]) begin
          m_data[d] = s_data[d];
          m_len[d]  = (s_len[d] == 0 || s_len[d] > 8) ?
                      8 : int'(s_len[d]);
          m_left[d] = m_len[d];
          m_pos[d]  = 0;
        end
      end
    end

    @(negedge clk);
    s_valid = 2'b00;
    abort   = 2'b00;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
